user_input_fifo: RTL and testbench
==================================

USER_INPUT_FIFO -- requirements
Module: user_input_fifo

Interface
REQ-001 Parameter PAYLOAD_BITS, default 32: width of one data word.
REQ-002 Parameter ADDR_BITS, default 2: storage depth is DEPTH = 2^ADDR_BITS words; legal range is 1 to 6.
REQ-003 Port clk_user, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 Port din, input, PAYLOAD_BITS: word from the leaf interface output port.
REQ-006 Port vld_in, input, 1: din is valid.
REQ-007 Port ack_out, output, 1: word accepted; returned to the leaf interface.
REQ-008 Port dout, output, PAYLOAD_BITS: head word presented to the user kernel.
REQ-009 Port vld_out, output, 1: dout is valid.
REQ-010 Port rdy_in, input, 1: the user kernel accepts dout this cycle.
REQ-011 Port count, output, ADDR_BITS+1: current occupancy, 0 to DEPTH.
REQ-012 Port almost_full, output, 1: high when count >= DEPTH-1.
REQ-013 Port words_in, output, 32: total number of accepted pushes.

Function
REQ-014 Push: when vld_in=1 and ack_out=1 in the same cycle, din is written at wr_ptr and wr_ptr increments.
REQ-015 ack_out = (count != DEPTH).
- ack_out is driven from state only and never depends on vld_in in the same cycle.
- ack_out may be high while vld_in=0.
REQ-016 Pop: when vld_out=1 and rdy_in=1 in the same cycle, rd_ptr increments.
REQ-017 vld_out = (count != 0).
REQ-018 dout = mem[rd_ptr] (first-word fall-through).
- A pushed word is visible on dout in the cycle after the push: latency 1 cycle when the FIFO was empty.
- No write-through bypass exists: push and pop in the same cycle while empty are impossible, because vld_out=0.
REQ-019 Pointers are ADDR_BITS wide and wrap from DEPTH-1 to 0 with no gap.
REQ-020 count next-state:
- push only: +1.
- pop only: -1.
- push and pop together, or neither: unchanged.
REQ-021 Full (count=DEPTH): ack_out=0. A simultaneous pop in that cycle does not enable a push in the same cycle; ack_out rises in the following cycle.
REQ-022 Empty (count=0): rdy_in is ignored, and pointers and count do not change on the pop side.
REQ-023 dout holds its value while vld_out=1 and rdy_in=0.
REQ-024 words_in increments by 1 per push and wraps from 0xFFFFFFFF to 0.
REQ-025 Overflow and underflow are not representable; no error outputs exist.

Reset
REQ-026 reset_n=0 asynchronously clears the following, independent of clk_user:
- wr_ptr, rd_ptr, count and words_in to 0;
- hence vld_out=0, ack_out=1 and almost_full=0.
REQ-027 Storage contents are not reset, and dout is don't-care while vld_out=0.
REQ-028 Reset asserted mid-operation discards all stored words; no push or pop completes in a cycle in which reset_n=0.
REQ-029 Reset deassertion is synchronised externally. The first push can be accepted on the first rising edge with reset_n=1.

Verification
REQ-030 Single word: hold rdy_in=0, push 0xA5A5_0001 once -> next cycle vld_out=1, dout=0xA5A5_0001, count=1; pulse rdy_in -> count=0, vld_out=0.
REQ-031 Fill (DEPTH=4), rdy_in=0, push 0x10..0x13 on four consecutive cycles:
- count goes 1,2,3,4;
- almost_full=1 from count 3;
- ack_out=0 at count 4;
- a fifth word 0x14 held on din is not accepted, and words_in=4.
REQ-032 Full with pop: at count=4, assert rdy_in for one cycle with vld_in=1 -> 0x10 popped, count=3, ack_out=0 in that cycle and 1 the next; 0x14 is accepted one cycle later and count returns to 4.
REQ-033 Wrap and streaming: vld_in=1 and rdy_in=1 continuously for 20 words 0..19 -> dout order 0..19, no loss or duplication, pointers wrap 5 times, count steady at 1 after the first cycle.
REQ-034 Random: random vld_in and rdy_in for 10,000 cycles, checked against a scoreboard queue:
- output order matches input order;
- count equals the model at every cycle;
- ack_out=0 exactly when count=4.
REQ-035 Async reset: with count=3, pull reset_n low between clock edges -> vld_out=0, count=0 and ack_out=1 immediately, without a clock edge; after release, push 0x55 -> dout=0x55 next cycle.

Source files
------------

// File: rtl/user_input_fifo.sv
// ---------------------------------------------------------------------------
// user_input_fifo
//   First-word fall-through FIFO between a leaf interface (producer) and a
//   user kernel (consumer). Handshakes are valid/ack on the input side and
//   valid/ready on the output side. ack_out and vld_out are derived from
//   registered occupancy only, so neither side sees a combinational path
//   from the other.
//
// Parameters
//   PAYLOAD_BITS : width of one data word
//   ADDR_BITS    : log2 of storage depth (1..6), DEPTH = 2**ADDR_BITS
//
// Ports
//   clk_user    : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   din         : word offered by the leaf interface
//   vld_in      : din is valid
//   ack_out     : word accepted this cycle (FIFO not full)
//   dout        : head word presented to the user kernel
//   vld_out     : dout is valid (FIFO not empty)
//   rdy_in      : user kernel takes dout this cycle
//   count       : occupancy, 0..DEPTH
//   almost_full : count >= DEPTH-1
//   words_in    : free-running count of accepted pushes (wraps)
// ---------------------------------------------------------------------------
module user_input_fifo #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned ADDR_BITS    = 2
) (
  input  logic                    clk_user,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    rdy_in,
  output logic [ADDR_BITS:0]      count,
  output logic                    almost_full,
  output logic [31:0]             words_in
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  localparam logic [ADDR_BITS:0]   FULL_CNT = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   AF_CNT   = (ADDR_BITS+1)'(DEPTH - 1);
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]    wr_ptr;
  logic [ADDR_BITS-1:0]    rd_ptr;
  logic [ADDR_BITS:0]      count_q;
  logic [31:0]             words_q;
  logic                    push;
  logic                    pop;

  // Flags come from registered occupancy only; a pop on a full cycle
  // therefore frees a slot that becomes visible one cycle later.
  always_comb begin
    ack_out     = (count_q != FULL_CNT);
    vld_out     = (count_q != '0);
    almost_full = (count_q >= AF_CNT);
    push        = vld_in & ack_out;
    pop         = vld_out & rdy_in;
    dout        = mem[rd_ptr];
    count       = count_q;
    words_in    = words_q;
  end

  // Storage is not reset; a stale word is never exposed because vld_out
  // tracks count.
  always_ff @(posedge clk_user) begin
    if (push && reset_n) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      words_q <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        words_q <= words_q + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_user_input_fifo.sv
module tb_user_input_fifo;

  localparam int unsigned W     = 32;
  localparam int unsigned AB    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk_user;
  logic          reset_n;
  logic [W-1:0]  din;
  logic          vld_in;
  logic          ack_out;
  logic [W-1:0]  dout;
  logic          vld_out;
  logic          rdy_in;
  logic [AB:0]   count;
  logic          almost_full;
  logic [31:0]   words_in;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  user_input_fifo #(.PAYLOAD_BITS(W), .ADDR_BITS(AB)) dut (
    .clk_user    (clk_user),
    .reset_n     (reset_n),
    .din         (din),
    .vld_in      (vld_in),
    .ack_out     (ack_out),
    .dout        (dout),
    .vld_out     (vld_out),
    .rdy_in      (rdy_in),
    .count       (count),
    .almost_full (almost_full),
    .words_in    (words_in)
  );

  initial begin
    clk_user = 1'b0;
    forever #5 clk_user = ~clk_user;
  end

  // Behavioural model: a queue of stored words plus a push counter.
  logic [31:0] mq[$];
  logic [31:0] mwords = '0;

  always @(negedge reset_n) begin
    mq.delete();
    mwords = '0;
  end

  always @(posedge clk_user) begin
    if (reset_n) begin
      automatic bit do_push = vld_in && (mq.size() != DEPTH);
      automatic bit do_pop  = rdy_in && (mq.size() != 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(din);
        mwords = mwords + 32'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_user) begin
    automatic int unsigned n = mq.size();
    chk("m_count",   32'(count), 32'(n));
    chk("m_vld_out", 32'(vld_out), 32'(n != 0));
    chk("m_ack_out", 32'(ack_out), 32'(n != DEPTH));
    chk("m_afull",   32'(almost_full), 32'(n >= DEPTH - 1));
    chk("m_words",   words_in, mwords);
    if (n != 0) chk("m_dout", dout, mq[0]);
  end

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  // Called at posedge+1 with inputs idle; completes before the next negedge.
  task automatic do_reset();
    vld_in  = 1'b0;
    rdy_in  = 1'b0;
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    vld_in  = 1'b0;
    rdy_in  = 1'b0;
    din     = '0;

    // Reset state
    #3;
    chk("rst_vld_out", 32'(vld_out), 32'd0);
    chk("rst_ack_out", 32'(ack_out), 32'd1);
    chk("rst_count",   32'(count), 32'd0);
    chk("rst_afull",   32'(almost_full), 32'd0);
    chk("rst_words",   words_in, 32'd0);
    #9 reset_n = 1'b1;
    tick();

    // Single word
    din = 32'hA5A5_0001; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    chk("single_vld", 32'(vld_out), 32'd1);
    chk("single_dout", dout, 32'hA5A5_0001);
    chk("single_count", 32'(count), 32'd1);
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    chk("single_pop_count", 32'(count), 32'd0);
    chk("single_pop_vld", 32'(vld_out), 32'd0);

    // Fill
    do_reset();
    for (int i = 0; i < 4; i++) begin
      din = 32'h10 + 32'(i); vld_in = 1'b1;
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 3));
      chk("fill_ack",   32'(ack_out), 32'(i + 1 != 4));
    end
    din = 32'h14;
    tick();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_words", words_in, 32'd4);
    chk("full_hold_dout",  dout, 32'h10);

    // Full with simultaneous pop: push stays blocked for that cycle
    rdy_in = 1'b1;
    chk("fullpop_ack_before", 32'(ack_out), 32'd0);
    tick();
    rdy_in = 1'b0;
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_ack_after", 32'(ack_out), 32'd1);
    chk("fullpop_dout", dout, 32'h11);
    chk("fullpop_words", words_in, 32'd4);
    tick();
    vld_in = 1'b0;
    chk("refill_count", 32'(count), 32'd4);
    chk("refill_words", words_in, 32'd5);
    rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_dout", dout, 32'h11 + 32'(i));
      tick();
    end
    rdy_in = 1'b0;
    chk("drain_count", 32'(count), 32'd0);

    // Streaming with pointer wrap
    do_reset();
    vld_in = 1'b1; rdy_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 32'(i);
      tick();
      chk("stream_dout",  dout, 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    vld_in = 1'b0;
    tick();
    rdy_in = 1'b0;
    chk("stream_end_count", 32'(count), 32'd0);
    chk("stream_words", words_in, 32'd20);

    // Random traffic; phases bias toward full and toward empty
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      automatic int unsigned pv = ((i / 500) % 2 == 0) ? 70 : 35;
      vld_in = ($urandom_range(0, 99) < pv);
      rdy_in = ($urandom_range(0, 99) < (105 - pv));
      din    = $urandom;
      tick();
    end
    vld_in = 1'b0;
    rdy_in = 1'b0;
    tick();

    // Asynchronous reset between edges
    do_reset();
    vld_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 32'hC0 + 32'(i);
      tick();
    end
    vld_in = 1'b0;
    chk("pre_async_count", 32'(count), 32'd3);
    #1 reset_n = 1'b0;
    #1;
    chk("async_vld_out", 32'(vld_out), 32'd0);
    chk("async_count",   32'(count), 32'd0);
    chk("async_ack",     32'(ack_out), 32'd1);
    chk("async_words",   words_in, 32'd0);
    #1 reset_n = 1'b1;
    tick();
    din = 32'h55; vld_in = 1'b1;
    tick();
    vld_in = 1'b0;
    chk("post_rst_dout",  dout, 32'h55);
    chk("post_rst_count", 32'(count), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
